// File: rtl/snake_pkg.sv
// Shared types and constants for the snake head sequencer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DEAD  = 2'd3
  } game_state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

  localparam logic [9:0] SCORE_MAX = '1;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_key_decode.sv
// Decodes two USB HID key slots into a direction request and start/pause edge events.
module snake_key_decode
  import snake_pkg::*;
(
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  output logic        dir_valid,
  output logic [1:0]  dir_code,
  output logic        start_evt,
  output logic        pause_evt
);

  logic [7:0] slot0, slot1;
  logic [7:0] prev0, prev1;
  logic [2:0] dec0, dec1;

  assign slot0 = keycode[7:0];
  assign slot1 = keycode[15:8];

  function automatic logic [2:0] dir_of(input logic [7:0] k);
    case (k)
      KEY_W:   return {1'b1, DIR_UP};
      KEY_D:   return {1'b1, DIR_RIGHT};
      KEY_S:   return {1'b1, DIR_DOWN};
      KEY_A:   return {1'b1, DIR_LEFT};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic in_slots(input logic [7:0] k, input logic [7:0] a,
                                    input logic [7:0] b);
    return (a == k) || (b == k);
  endfunction

  assign dec0 = dir_of(slot0);
  assign dec1 = dir_of(slot1);

  // slot1 is applied first so that slot0 overrides it when both hold a direction
  always_comb begin
    dir_valid = 1'b0;
    dir_code  = DIR_RIGHT;
    if (dec1[2]) begin
      dir_valid = 1'b1;
      dir_code  = dec1[1:0];
    end
    if (dec0[2]) begin
      dir_valid = 1'b1;
      dir_code  = dec0[1:0];
    end
  end

  assign start_evt = in_slots(KEY_SPACE, slot0, slot1) && !in_slots(KEY_SPACE, prev0, prev1);
  assign pause_evt = in_slots(KEY_P, slot0, slot1) && !in_slots(KEY_P, prev0, prev1);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev0 <= '0;
      prev1 <= '0;
    end else begin
      prev0 <= slot0;
      prev1 <= slot1;
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Frame-rate game sequencer for the snake head: direction buffering, stepping,
// wall collision, score and the IDLE/PLAY/PAUSE/DEAD state machine.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int START_COL = 13,
  parameter int START_ROW = 15,
  parameter int INIT_DIV  = 8,
  parameter int MIN_DIV   = 2,
  parameter int DIV_W     = 6
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic        food_eaten,
  output logic [5:0]  head_col,
  output logic [4:0]  head_row,
  output logic [1:0]  dir,
  output logic        step,
  output logic [1:0]  state,
  output logic [9:0]  score,
  output logic        game_over
);

  localparam logic [5:0]       COL_START = 6'(START_COL);
  localparam logic [4:0]       ROW_START = 5'(START_ROW);
  localparam logic [5:0]       COL_MAX   = 6'(GRID_W - 1);
  localparam logic [4:0]       ROW_MAX   = 5'(GRID_H - 1);
  localparam logic [DIV_W-1:0] LIM_INIT  = DIV_W'(INIT_DIV);
  localparam logic [DIV_W-1:0] LIM_MIN   = DIV_W'(MIN_DIV);

  logic        dir_valid, start_evt, pause_evt;
  logic [1:0]  dir_code;

  snake_key_decode u_key_decode (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .dir_valid (dir_valid),
    .dir_code  (dir_code),
    .start_evt (start_evt),
    .pause_evt (pause_evt)
  );

  game_state_t      st_q, st_d;
  dir_t             dir_q, dir_d, pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [5:0]       col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic             step_q, step_d;
  logic [9:0]       score_q, score_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, lim_q, lim_d;

  dir_t       key_dir, ref_dir, new_dir;
  logic       key_ok, due, hit;
  logic [5:0] nxt_col;
  logic [4:0] nxt_row;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      st_q     <= ST_IDLE;
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      pend_v_q <= 1'b0;
      col_q    <= COL_START;
      row_q    <= ROW_START;
      step_q   <= 1'b0;
      score_q  <= '0;
      cnt_q    <= '0;
      lim_q    <= LIM_INIT;
    end else begin
      st_q     <= st_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      col_q    <= col_d;
      row_q    <= row_d;
      step_q   <= step_d;
      score_q  <= score_d;
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
    end
  end

  always_comb begin
    key_dir = dir_t'(dir_code);
    ref_dir = pend_v_q ? pend_q : dir_q;
    key_ok  = dir_valid && (key_dir != ref_dir) && (key_dir != opposite(ref_dir));
    // a key accepted on the step frame itself is committed by that step
    if (key_ok)        new_dir = key_dir;
    else if (pend_v_q) new_dir = pend_q;
    else               new_dir = dir_q;

    // >= rather than == keeps the divider bounded when div_limit shrinks mid-window
    due = (cnt_q >= (lim_q - 1'b1));

    nxt_col = col_q;
    nxt_row = row_q;
    hit     = 1'b0;
    case (new_dir)
      DIR_UP:    begin nxt_row = row_q - 1'b1; hit = (row_q == '0);     end
      DIR_RIGHT: begin nxt_col = col_q + 1'b1; hit = (col_q == COL_MAX); end
      DIR_DOWN:  begin nxt_row = row_q + 1'b1; hit = (row_q == ROW_MAX); end
      default:   begin nxt_col = col_q - 1'b1; hit = (col_q == '0);     end
    endcase
  end

  always_comb begin
    st_d     = st_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    col_d    = col_q;
    row_d    = row_q;
    step_d   = 1'b0;
    score_d  = score_q;
    cnt_d    = cnt_q;
    lim_d    = lim_q;

    case (st_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_evt) st_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (food_eaten && (score_q != SCORE_MAX)) begin
          score_d = score_q + 1'b1;
          if ((score_q[1:0] == 2'b11) && (lim_q > LIM_MIN)) lim_d = lim_q - 1'b1;
        end
        if (pause_evt) begin
          st_d = ST_PAUSE;
        end else begin
          if (key_ok) begin
            pend_d   = key_dir;
            pend_v_d = 1'b1;
          end
          if (due) begin
            cnt_d    = '0;
            dir_d    = new_dir;
            pend_v_d = 1'b0;
            if (hit) begin
              st_d = ST_DEAD;
            end else begin
              col_d  = nxt_col;
              row_d  = nxt_row;
              step_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (pause_evt) begin
          st_d  = ST_PLAY;
          cnt_d = '0;
        end
      end

      default: begin
        if (start_evt) begin
          st_d     = ST_IDLE;
          dir_d    = DIR_RIGHT;
          pend_v_d = 1'b0;
          col_d    = COL_START;
          row_d    = ROW_START;
          score_d  = '0;
          cnt_d    = '0;
          lim_d    = LIM_INIT;
        end
      end
    endcase
  end

  assign head_col  = col_q;
  assign head_row  = row_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign state     = st_q;
  assign score     = score_q;
  assign game_over = (st_q == ST_DEAD);

endmodule
